// File: rtl/mac_job_sequencer_if.sv
// Host-side channels of the MAC job sequencer: the command, the operand
// stream and the result, each with a valid/ready handshake.
interface mac_job_sequencer_if #(
  parameter int DEPTH = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [$clog2(DEPTH):0]   cmd_len;
  logic                     op_valid;
  logic                     op_ready;
  logic [7:0]               op_a;
  logic [7:0]               op_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [15:0]              res_data;
  logic [1:0]               res_status;

  // Job producer / result consumer side
  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_status
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_status
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// Job controller for the error-checked 8x8 MAC datapath. A job is buffered,
// issued one operand pair per cycle after a MAC clear, checked for datapath
// errors once the MAC pipeline has drained, and replayed from the buffer on
// error up to MAX_RETRY times before the result is reported.
module mac_job_sequencer #(
  parameter int DEPTH     = 16,
  parameter int MAC_LAT   = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_job_sequencer_if.slave    host,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic [7:0]            mac_a,
  output logic [7:0]            mac_b,
  input  logic [15:0]           mac_acc,
  input  logic                  mac_err,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int TW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RETRIED = 2'b01;
  localparam logic [1:0] ST_FAILED  = 2'b10;
  localparam logic [1:0] ST_BAD_CMD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_CHECK,
    S_RESULT
  } state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   len_reg, len_next;
  logic [LW-1:0]   wr_idx_reg, wr_idx_next;
  logic [LW-1:0]   rd_idx_reg, rd_idx_next;
  logic [DW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [TW-1:0]   attempt_reg, attempt_next;
  logic            err_seen_reg, err_seen_next;
  logic [15:0]     res_data_reg, res_data_next;
  logic [1:0]      res_status_reg, res_status_next;

  // Operand buffer: one byte lane per operand, each a RAM with registered read.
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic [1:0][7:0]     lane_wdata;
  logic [1:0][7:0]     lane_rdata;

  assign wr_en         = (state_reg == S_LOAD) && host.op_valid;
  assign wr_addr       = wr_idx_reg[AW-1:0];
  // Reading at the next index makes buf[rd_idx] appear exactly while issuing it.
  assign rd_addr       = rd_idx_next[AW-1:0];
  assign lane_wdata[0] = host.op_a;
  assign lane_wdata[1] = host.op_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Buffer write on operand handshake; registered read for issue
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= lane_wdata[gi];
      end
      rd_q <= mem[rd_addr];
    end

    assign lane_rdata[gi] = rd_q;
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      len_reg        <= '0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      drain_cnt_reg  <= '0;
      attempt_reg    <= '0;
      err_seen_reg   <= 1'b0;
      res_data_reg   <= '0;
      res_status_reg <= '0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      wr_idx_reg     <= wr_idx_next;
      rd_idx_reg     <= rd_idx_next;
      drain_cnt_reg  <= drain_cnt_next;
      attempt_reg    <= attempt_next;
      err_seen_reg   <= err_seen_next;
      res_data_reg   <= res_data_next;
      res_status_reg <= res_status_next;
    end
  end

  // Next-state and counter update for the job sequence
  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    wr_idx_next     = wr_idx_reg;
    rd_idx_next     = rd_idx_reg;
    drain_cnt_next  = drain_cnt_reg;
    attempt_next    = attempt_reg;
    err_seen_next   = err_seen_reg;
    res_data_next   = res_data_reg;
    res_status_next = res_status_reg;

    case (state_reg)
      S_IDLE: begin
        if (host.cmd_valid) begin
          if (host.cmd_len != '0 && host.cmd_len <= LW'(DEPTH)) begin
            len_next     = host.cmd_len;
            wr_idx_next  = '0;
            attempt_next = '0;
            state_next   = S_LOAD;
          end else begin
            res_data_next   = '0;
            res_status_next = ST_BAD_CMD;
            state_next      = S_RESULT;
          end
        end
      end

      S_LOAD: begin
        if (host.op_valid) begin
          wr_idx_next = wr_idx_reg + LW'(1);
          if (wr_idx_reg + LW'(1) == len_reg) begin
            state_next = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        err_seen_next = 1'b0;
        rd_idx_next   = '0;
        state_next    = S_ISSUE;
      end

      S_ISSUE: begin
        err_seen_next = err_seen_reg | mac_err;
        rd_idx_next   = rd_idx_reg + LW'(1);
        if (rd_idx_reg == len_reg - LW'(1)) begin
          drain_cnt_next = '0;
          state_next     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        err_seen_next  = err_seen_reg | mac_err;
        drain_cnt_next = drain_cnt_reg + DW'(1);
        if (drain_cnt_reg == DW'(MAC_LAT - 1)) begin
          state_next = S_CHECK;
        end
      end

      S_CHECK: begin
        res_data_next = mac_acc;
        if (!err_seen_reg) begin
          res_status_next = (attempt_reg == '0) ? ST_OK : ST_RETRIED;
          state_next      = S_RESULT;
        end else if (attempt_reg < TW'(MAX_RETRY)) begin
          // Replay the same buffered operands; nothing is re-fetched.
          attempt_next = attempt_reg + TW'(1);
          state_next   = S_CLEAR;
        end else begin
          res_status_next = ST_FAILED;
          state_next      = S_RESULT;
        end
      end

      S_RESULT: begin
        if (host.res_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decode from the state register only (plus registered data).
  assign busy            = (state_reg != S_IDLE);
  assign host.cmd_ready  = (state_reg == S_IDLE);
  assign host.op_ready   = (state_reg == S_LOAD);
  assign host.res_valid  = (state_reg == S_RESULT);
  assign host.res_data   = host.res_valid ? res_data_reg : 16'h0000;
  assign host.res_status = host.res_valid ? res_status_reg : 2'b00;
  assign mac_clr         = (state_reg == S_CLEAR);
  assign mac_en          = (state_reg == S_ISSUE);
  assign mac_a           = mac_en ? lane_rdata[0] : 8'h00;
  assign mac_b           = mac_en ? lane_rdata[1] : 8'h00;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Randomized bench for mac_job_sequencer with an ideal MAC behind it and a
// job-level reference: expected result is the wrapped dot product, expected
// status/attempt count/latency come from the error pattern injected.
module tb_mac_job_sequencer;

  localparam int DEPTH     = 16;
  localparam int MAC_LAT   = 2;
  localparam int MAX_RETRY = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mac_clr;
  logic        mac_en;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_acc;
  logic        mac_err = 1'b0;
  logic        busy;

  mac_job_sequencer_if #(.DEPTH(DEPTH)) host_if ();

  mac_job_sequencer #(
    .DEPTH     (DEPTH),
    .MAC_LAT   (MAC_LAT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host_if),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_acc (mac_acc),
    .mac_err (mac_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] ja [DEPTH];
  logic [7:0] jb [DEPTH];
  int jlen      = 1;
  int clr_cnt   = 0;
  int en_cnt    = 0;
  int en_base   = 0;
  int idle_bad  = 0;
  int issue_bad = 0;
  int err_mode  = 0;
  int pulse_idx = 0;

  logic [15:0] s_acc    = 16'h0;
  logic [15:0] acc_pipe = 16'h0;
  assign mac_acc = acc_pipe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ideal MAC (MAC_LAT=2) plus issue monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s_acc    <= 16'h0;
      acc_pipe <= 16'h0;
    end else begin
      if (mac_clr) s_acc <= 16'h0;
      else if (mac_en) s_acc <= s_acc + 16'(mac_a) * 16'(mac_b);
      acc_pipe <= s_acc;
      if (mac_clr) clr_cnt <= clr_cnt + 1;
      if (mac_en) begin
        if (mac_a !== ja[(en_cnt - en_base) % jlen] || mac_b !== jb[(en_cnt - en_base) % jlen])
          issue_bad <= issue_bad + 1;
        en_cnt <= en_cnt + 1;
      end
      if (!mac_en && (mac_a !== 8'h0 || mac_b !== 8'h0)) idle_bad <= idle_bad + 1;
    end
  end

  // Error injection: 1 = single pulse at a chosen first-attempt issue cycle, 2 = held
  always @(negedge clk) begin
    mac_err = (err_mode == 2) ||
              (err_mode == 1 && mac_en && (en_cnt - en_base) == pulse_idx);
  end

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 32'(host_if.cmd_ready), 1);
    check({tag, "_op_ready"},  32'(host_if.op_ready), 0);
    check({tag, "_res_valid"}, 32'(host_if.res_valid), 0);
    check({tag, "_res_data"},  32'(host_if.res_data), 0);
    check({tag, "_res_status"}, 32'(host_if.res_status), 0);
    check({tag, "_mac_clr"},   32'(mac_clr), 0);
    check({tag, "_mac_en"},    32'(mac_en), 0);
    check({tag, "_mac_ab"},    32'({mac_a, mac_b}), 0);
    check({tag, "_busy"},      32'(busy), 0);
  endtask

  task automatic start_job(input int len, input int emode, input int pulse_at);
    @(negedge clk);
    jlen      = len;
    en_base   = en_cnt;
    err_mode  = emode;
    pulse_idx = pulse_at;
    check("cmd_ready", 32'(host_if.cmd_ready), 1);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_len   = LW'(len);
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    check("busy_after_cmd", 32'(busy), 1);
  endtask

  task automatic send_ops(input int len, input bit gaps, output int c_last);
    int i;
    int guard;
    i = 0;
    guard = 0;
    c_last = 0;
    while (i < len && guard < 500) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        host_if.op_valid = 1'b0;
      end else begin
        host_if.op_valid = 1'b1;
        host_if.op_a     = ja[i];
        host_if.op_b     = jb[i];
        if (host_if.op_ready) begin
          c_last = cyc;
          i++;
        end
      end
      @(negedge clk);
    end
    host_if.op_valid = 1'b0;
    check("ops_accepted", i, len);
  endtask

  task automatic run_job(input int len, input int emode, input int pulse_at,
                         input bit gaps, input int rdy_delay);
    int c_last, attempts, clr0, ib0, guard, lat;
    logic [15:0] exp_sum;
    logic [1:0]  exp_st;
    exp_sum = 16'h0;
    for (int k = 0; k < len; k++) exp_sum += 16'(ja[k]) * 16'(jb[k]);
    attempts = (emode == 0) ? 1 : (emode == 1) ? 2 : MAX_RETRY + 1;
    exp_st   = (emode == 0) ? 2'b00 : (emode == 1) ? 2'b01 : 2'b10;
    clr0 = clr_cnt;
    ib0  = issue_bad;
    start_job(len, emode, pulse_at);
    send_ops(len, gaps, c_last);
    guard = 0;
    while (!host_if.res_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("res_valid", 32'(host_if.res_valid), 1);
    if (!host_if.res_valid) return;
    lat = cyc - c_last;
    check("latency", lat, 3 + len + MAC_LAT + (attempts - 1) * (2 + len + MAC_LAT));
    check("clr_pulses", clr_cnt - clr0, attempts);
    check("en_cycles", en_cnt - en_base, attempts * len);
    check("issue_order", issue_bad - ib0, 0);
    for (int d = 0; d < rdy_delay; d++) begin
      check("hold_valid", 32'(host_if.res_valid), 1);
      check("hold_data", 32'(host_if.res_data), 32'(exp_sum));
      check("hold_status", 32'(host_if.res_status), 32'(exp_st));
      check("hold_cmd_ready", 32'(host_if.cmd_ready), 0);
      @(negedge clk);
    end
    check("res_data", 32'(host_if.res_data), 32'(exp_sum));
    check("res_status", 32'(host_if.res_status), 32'(exp_st));
    $display("job len=%0d err_mode=%0d res_data=%04h status=%0d latency=%0d",
             len, emode, host_if.res_data, host_if.res_status, lat);
    host_if.res_ready = 1'b1;
    @(negedge clk);
    host_if.res_ready = 1'b0;
    check("res_dropped", 32'(host_if.res_valid), 0);
    check("back_idle", 32'(host_if.cmd_ready), 1);
    err_mode = 0;
  endtask

  task automatic bad_cmd(input int len);
    @(negedge clk);
    err_mode = 0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_len   = LW'(len);
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    check("bad_op_ready", 32'(host_if.op_ready), 0);
    check("bad_res_valid", 32'(host_if.res_valid), 1);
    check("bad_res_data", 32'(host_if.res_data), 0);
    check("bad_res_status", 32'(host_if.res_status), 3);
    $display("bad cmd len=%0d res_valid=%0d status=%0d", len, host_if.res_valid, host_if.res_status);
    host_if.res_ready = 1'b1;
    @(negedge clk);
    host_if.res_ready = 1'b0;
    check("bad_back_idle", 32'(host_if.cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_last;
    int guard;
    int len;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_len   = '0;
    host_if.op_valid  = 1'b0;
    host_if.op_a      = 8'h0;
    host_if.op_b      = 8'h0;
    host_if.res_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin ja[k] = 8'h0; jb[k] = 8'h0; end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Directed: len=3 dot product, clean, then one-pulse error, then held error
    ja[0] = 8'd2; jb[0] = 8'd3;
    ja[1] = 8'd4; jb[1] = 8'd5;
    ja[2] = 8'd6; jb[2] = 8'd7;
    run_job(3, 0, 0, 1'b0, 0);
    run_job(3, 1, 0, 1'b0, 0);
    run_job(3, 2, 0, 1'b0, 1);

    // Illegal lengths
    bad_cmd(0);
    bad_cmd(17);

    // Full-depth job with wrap-around and a stalled result consumer
    for (int k = 0; k < DEPTH; k++) begin ja[k] = 8'hFF; jb[k] = 8'hFF; end
    run_job(16, 0, 0, 1'b0, 5);

    // Reset in the middle of issuing a len=8 job
    for (int k = 0; k < 8; k++) begin ja[k] = 8'($urandom); jb[k] = 8'($urandom); end
    start_job(8, 0, 0);
    send_ops(8, 1'b0, c_last);
    guard = 0;
    while ((en_cnt - en_base) < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reset_in_issue", 32'(mac_en), 1);
    rst = 1'b1;
    #1;
    check_idle("midjob_rst");
    $display("reset asserted during issue at cycle %0d", cyc);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_result_after_rst", 32'(host_if.res_valid), 0);
    end
    ja[0] = 8'd3; jb[0] = 8'd4;
    run_job(1, 0, 0, 1'b0, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(1, DEPTH);
      for (int k = 0; k < len; k++) begin
        ja[k] = 8'($urandom);
        jb[k] = 8'($urandom);
      end
      run_job(len, $urandom_range(0, 2), $urandom_range(0, len - 1), 1'b1,
              $urandom_range(0, 3));
    end

    check("mac_ab_zero_when_idle", idle_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
